// File: rtl/prach_ditfft3_bf3.sv
// Radix-3 DIT FFT final butterfly: takes a, b, c per group and emits
// y0 = a, y1 = sat(b+c), y2 = sat(b-c) as a gap-free three-sample burst.
module prach_ditfft3_bf3 (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [17:0] din_dr,
    input  logic signed [17:0] din_di,
    input  logic               din_dv,
    input  logic               sync_in,
    output logic signed [17:0] dout_dr,
    output logic signed [17:0] dout_di,
    output logic               dout_dv,
    output logic               sync_out,
    output logic               sat_flag
);

    typedef enum logic [1:0] {POS_A, POS_B, POS_C} pos_t;
    typedef enum logic [1:0] {DR_IDLE, DR_Y0, DR_Y1, DR_Y2} drain_t;

    pos_t   pos;
    drain_t drain;

    logic signed [17:0] a_dr, a_di, b_dr, b_di, c_dr, c_di;
    logic               a_sync;
    logic               c_done;

    logic signed [17:0] q_y0r, q_y0i, q_y1r, q_y1i, q_y2r, q_y2i;
    logic               q_sync, q_sat1, q_sat2;

    logic signed [18:0] sum_r, sum_i, dif_r, dif_i;
    logic signed [17:0] y1r, y1i, y2r, y2i;
    logic               y1r_f, y1i_f, y2r_f, y2i_f;

    // Bit [18] of the result is the clip flag, [17:0] the clamped value.
    function automatic logic [18:0] sat18(input logic signed [18:0] v);
        logic [18:0] r;
        if (v[18] != v[17])
            r = {1'b1, (v[18] ? 18'h20000 : 18'h1FFFF)};
        else
            r = {1'b0, v[17:0]};
        return r;
    endfunction

    always_comb begin
        sum_r = {b_dr[17], b_dr} + {c_dr[17], c_dr};
        sum_i = {b_di[17], b_di} + {c_di[17], c_di};
        dif_r = {b_dr[17], b_dr} - {c_dr[17], c_dr};
        dif_i = {b_di[17], b_di} - {c_di[17], c_di};
        {y1r_f, y1r} = sat18(sum_r);
        {y1i_f, y1i} = sat18(sum_i);
        {y2r_f, y2r} = sat18(dif_r);
        {y2i_f, y2i} = sat18(dif_i);
    end

    // Capture side: a sync always restarts the group, dropping any partial a/b.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos    <= POS_A;
            a_dr   <= '0;
            a_di   <= '0;
            a_sync <= 1'b0;
            b_dr   <= '0;
            b_di   <= '0;
            c_dr   <= '0;
            c_di   <= '0;
            c_done <= 1'b0;
        end else begin
            c_done <= 1'b0;
            if (din_dv) begin
                if (sync_in || pos == POS_A) begin
                    a_dr   <= din_dr;
                    a_di   <= din_di;
                    a_sync <= sync_in;
                    pos    <= POS_B;
                end else if (pos == POS_B) begin
                    b_dr <= din_dr;
                    b_di <= din_di;
                    pos  <= POS_C;
                end else begin
                    c_dr   <= din_dr;
                    c_di   <= din_di;
                    c_done <= 1'b1;
                    pos    <= POS_A;
                end
            end
        end
    end

    // Drain side: a new load on the y2 cycle wins the state, so bursts abut.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain    <= DR_IDLE;
            q_y0r    <= '0;
            q_y0i    <= '0;
            q_y1r    <= '0;
            q_y1i    <= '0;
            q_y2r    <= '0;
            q_y2i    <= '0;
            q_sync   <= 1'b0;
            q_sat1   <= 1'b0;
            q_sat2   <= 1'b0;
            dout_dr  <= '0;
            dout_di  <= '0;
            dout_dv  <= 1'b0;
            sync_out <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            case (drain)
                DR_Y0: begin
                    dout_dr  <= q_y0r;
                    dout_di  <= q_y0i;
                    dout_dv  <= 1'b1;
                    sync_out <= q_sync;
                    sat_flag <= 1'b0;
                    drain    <= DR_Y1;
                end
                DR_Y1: begin
                    dout_dr  <= q_y1r;
                    dout_di  <= q_y1i;
                    dout_dv  <= 1'b1;
                    sync_out <= 1'b0;
                    sat_flag <= q_sat1;
                    drain    <= DR_Y2;
                end
                DR_Y2: begin
                    dout_dr  <= q_y2r;
                    dout_di  <= q_y2i;
                    dout_dv  <= 1'b1;
                    sync_out <= 1'b0;
                    sat_flag <= q_sat2;
                    drain    <= DR_IDLE;
                end
                default: begin
                    dout_dr  <= '0;
                    dout_di  <= '0;
                    dout_dv  <= 1'b0;
                    sync_out <= 1'b0;
                    sat_flag <= 1'b0;
                end
            endcase
            if (c_done) begin
                q_y0r  <= a_dr;
                q_y0i  <= a_di;
                q_y1r  <= y1r;
                q_y1i  <= y1i;
                q_y2r  <= y2r;
                q_y2i  <= y2i;
                q_sync <= a_sync;
                q_sat1 <= y1r_f | y1i_f;
                q_sat2 <= y2r_f | y2i_f;
                drain  <= DR_Y0;
            end
        end
    end

endmodule

// File: tb/tb_prach_ditfft3_bf3.sv
// Bench for prach_ditfft3_bf3: fixed vector table, hand sequences for
// stream/resync/reset, and randomized traffic against a cycle-indexed model.
module tb_prach_ditfft3_bf3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [17:0] din_dr, din_di;
    logic               din_dv, sync_in;
    logic signed [17:0] dout_dr, dout_di;
    logic               dout_dv, sync_out, sat_flag;

    always #5 clk = ~clk;

    prach_ditfft3_bf3 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_dr  (din_dr),
        .din_di  (din_di),
        .din_dv  (din_dv),
        .sync_in (sync_in),
        .dout_dr (dout_dr),
        .dout_di (dout_di),
        .dout_dv (dout_dv),
        .sync_out(sync_out),
        .sat_flag(sat_flag)
    );

    localparam int DEPTH = 8192;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected output at each clock edge, filled in as groups complete.
    int exp_dr [DEPTH];
    int exp_di [DEPTH];
    bit exp_dv [DEPTH];
    bit exp_sy [DEPTH];
    bit exp_sf [DEPTH];

    int pos_m = 0;
    int ma_r, ma_i, mb_r, mb_i;
    bit ma_s;

    int dv_cnt = 0, sy_cnt = 0, run = 0, max_run = 0;

    typedef struct {
        int ar, ai, br, bi, cr, ci;
        int gap;
        int y0r, y0i, y1r, y1i, y2r, y2i;
        bit s1, s2;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s @cyc %0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    function automatic int sat(input int v, output bit f);
        f = 1'b0;
        if (v > 131071)  begin f = 1'b1; return 131071;  end
        if (v < -131072) begin f = 1'b1; return -131072; end
        return v;
    endfunction

    function automatic int rnd18();
        case ($urandom % 6)
            0:       return 131071;
            1:       return -131072;
            default: return int'($urandom_range(0, 262143)) - 131072;
        endcase
    endfunction

    task automatic model_step(input bit dv, input bit sy, input int r, input int i);
        int e;
        bit f1, f2, f3, f4;
        int v1r, v1i, v2r, v2i;
        if (!dv) return;
        e = cyc + 1;
        if (sy || pos_m == 0) begin
            ma_r = r; ma_i = i; ma_s = sy; pos_m = 1;
        end else if (pos_m == 1) begin
            mb_r = r; mb_i = i; pos_m = 2;
        end else begin
            pos_m = 0;
            v1r = sat(mb_r + r, f1);
            v1i = sat(mb_i + i, f2);
            v2r = sat(mb_r - r, f3);
            v2i = sat(mb_i - i, f4);
            if (e + 4 < DEPTH) begin
                exp_dv[e+2] = 1; exp_sy[e+2] = ma_s; exp_sf[e+2] = 0;
                exp_dr[e+2] = ma_r; exp_di[e+2] = ma_i;
                exp_dv[e+3] = 1; exp_sy[e+3] = 0; exp_sf[e+3] = f1 | f2;
                exp_dr[e+3] = v1r; exp_di[e+3] = v1i;
                exp_dv[e+4] = 1; exp_sy[e+4] = 0; exp_sf[e+4] = f3 | f4;
                exp_dr[e+4] = v2r; exp_di[e+4] = v2i;
            end
        end
    endtask

    task automatic drive(input bit dv, input bit sy, input int r, input int i);
        @(negedge clk);
        din_dv  = dv;
        sync_in = sy;
        din_dr  = 18'(r);
        din_di  = 18'(i);
        model_step(dv, sy, r, i);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) drive(0, 0, 0, 0);
    endtask

    // Per-edge checker and activity counters.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (cyc < DEPTH) begin
            chk("out_ctl", int'({dout_dv, sync_out, sat_flag}),
                int'({exp_dv[cyc], exp_sy[cyc], exp_sf[cyc]}));
            chk("out_dr", int'(dout_dr), exp_dr[cyc]);
            chk("out_di", int'(dout_di), exp_di[cyc]);
        end
        if (dout_dv) begin
            dv_cnt++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (sync_out) sy_cnt++;
    end

    initial begin
        int snap_dv, snap_sy;
        tbl[0] = '{100, -8, 50, 4, 20, -2, 0, 100, -8, 70, 2, 30, 6, 0, 0};
        tbl[1] = '{0, 0, 131071, -131072, 10, 10, 0, 0, 0, 131071, -131062, 131061, -131072, 1, 1};
        tbl[2] = '{100, -8, 50, 4, 20, -2, 2, 100, -8, 70, 2, 30, 6, 0, 0};
        tbl[3] = '{5, 5, -131072, 131071, -1, 1, 1, 5, 5, -131072, 131071, -131071, 131070, 1, 0};
        tbl[4] = '{-7, 3, 0, 0, -131072, 131071, 0, -7, 3, -131072, 131071, 131071, -131071, 0, 1};

        rst_n = 1'b0; din_dv = 0; sync_in = 0; din_dr = '0; din_di = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", int'({dout_dv, sync_out, sat_flag}), 0);
        chk("reset_dr", int'(dout_dr), 0);
        chk("reset_di", int'(dout_di), 0);
        rst_n = 1'b1;
        idle(2);

        for (int t = 0; t < 5; t++) begin
            drive(1, 1, tbl[t].ar, tbl[t].ai);
            idle(tbl[t].gap);
            drive(1, 0, tbl[t].br, tbl[t].bi);
            idle(tbl[t].gap);
            drive(1, 0, tbl[t].cr, tbl[t].ci);
            drive(0, 0, 0, 0);
            @(posedge clk);
            @(posedge clk); #1;
            chk("tbl_y0_r", int'(dout_dr), tbl[t].y0r);
            chk("tbl_y0_i", int'(dout_di), tbl[t].y0i);
            chk("tbl_y0_ctl", int'({dout_dv, sync_out, sat_flag}), 3'b110);
            @(posedge clk); #1;
            chk("tbl_y1_r", int'(dout_dr), tbl[t].y1r);
            chk("tbl_y1_i", int'(dout_di), tbl[t].y1i);
            chk("tbl_y1_ctl", int'({dout_dv, sync_out, sat_flag}), int'({2'b10, tbl[t].s1}));
            @(posedge clk); #1;
            chk("tbl_y2_r", int'(dout_dr), tbl[t].y2r);
            chk("tbl_y2_i", int'(dout_di), tbl[t].y2i);
            chk("tbl_y2_ctl", int'({dout_dv, sync_out, sat_flag}), int'({2'b10, tbl[t].s2}));
            idle(3);
        end

        // Four back-to-back groups, sync on the first only.
        snap_dv = dv_cnt; snap_sy = sy_cnt; max_run = 0;
        for (int g = 0; g < 12; g++) drive(1, g == 0, rnd18(), rnd18());
        idle(10);
        chk("stream_dv", dv_cnt - snap_dv, 12);
        chk("stream_sync", sy_cnt - snap_sy, 1);
        chk("stream_run", max_run, 12);

        // Partial group a, b abandoned by a new sync.
        snap_dv = dv_cnt;
        drive(1, 1, 11, 12);
        drive(1, 0, 13, 14);
        drive(1, 1, 21, 22);
        drive(1, 0, 23, 24);
        drive(1, 0, 25, 26);
        idle(8);
        chk("resync_dv", dv_cnt - snap_dv, 3);

        // Reset asserted right after the y1 edge of a draining group.
        drive(1, 1, 300, 301);
        drive(1, 0, 400, 401);
        drive(1, 0, 500, 501);
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = cyc + 1; i < DEPTH; i++) begin
            exp_dv[i] = 0; exp_sy[i] = 0; exp_sf[i] = 0; exp_dr[i] = 0; exp_di[i] = 0;
        end
        pos_m = 0;
        #1;
        chk("rst_imm_ctl", int'({dout_dv, sync_out, sat_flag}), 0);
        chk("rst_imm_dr", int'(dout_dr), 0);
        chk("rst_imm_di", int'(dout_di), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snap_dv = dv_cnt;
        drive(1, 0, 7, 8);
        drive(1, 0, 9, 10);
        drive(1, 0, 1, 2);
        idle(8);
        chk("post_rst_dv", dv_cnt - snap_dv, 3);

        // Random traffic with idle gaps, stray syncs and extreme values.
        for (int n = 0; n < 800; n++)
            drive(($urandom % 4) != 0, ($urandom % 12) == 0, rnd18(), rnd18());
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
